// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcode map, sequencer state encoding and result entry layout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC;
    localparam logic [3:0] OP_NEG = 4'hD;
    localparam logic [3:0] OP_INC = 4'hE;
    localparam logic [3:0] OP_DEC = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] opcode;
        logic [3:0] data;
    } res_entry_t;

    function automatic logic is_div_zero(input logic [3:0] op, input logic [3:0] b);
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == 4'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_fifo.sv
// ---------------------------------------------------------------------------
// alu_seq_fifo : first-word fall-through result FIFO with full/empty flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB separates full from empty when the indices coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    assign wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : sweeps a combinational ALU over an opcode range, queues results
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [3:0] start_a,
    input  logic [3:0] start_b,
    input  logic [3:0] start_first,
    input  logic [3:0] start_last,
    input  logic       abort,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [3:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [3:0] res_opcode,
    output logic       res_err,
    output logic       busy,
    output logic       done
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [3:0] a_q;
    logic [3:0] a_d;
    logic [3:0] b_q;
    logic [3:0] b_d;
    logic [3:0] op_q;
    logic [3:0] op_d;
    logic [3:0] rem_q;
    logic [3:0] rem_d;

    logic       push_w;
    logic       done_w;
    logic       push_ok_w;
    logic       err_w;
    logic       fifo_full_w;
    logic       fifo_empty_w;
    res_entry_t entry_w;
    res_entry_t head_w;

    assign err_w         = is_div_zero(op_q, b_q);
    assign entry_w.err    = err_w;
    assign entry_w.opcode = op_q;
    assign entry_w.data   = err_w ? 4'h0 : alu_result;

    // A full FIFO still accepts the push when the head is leaving this cycle.
    assign push_ok_w = !fifo_full_w || res_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rem_d   = rem_q;
        push_w  = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = start_a;
                    b_d     = start_b;
                    op_d    = start_first;
                    rem_d   = start_last - start_first;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = abort ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (push_ok_w) begin
                    push_w = 1'b1;
                    if (rem_q != 4'h0) begin
                        op_d    = op_q + 4'h1;
                        rem_d   = rem_q - 4'h1;
                        state_d = ISSUE;
                    end else begin
                        done_w  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            op_q    <= 4'h0;
            rem_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(res_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_w),
        .wdata_i (entry_w),
        .pop_i   (res_ready),
        .rdata_o (head_w),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w)
    );

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_w;
    assign res_valid   = !fifo_empty_w;
    assign res_data    = head_w.data;
    assign res_opcode  = head_w.opcode;
    assign res_err     = head_w.err;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : directed table, corner sequences and random jobs for alu_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_seq;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [3:0] start_a = 4'h0;
    logic [3:0] start_b = 4'h0;
    logic [3:0] start_first = 4'h0;
    logic [3:0] start_last = 4'h0;
    logic       abort = 1'b0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_result;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic [3:0] res_opcode;
    logic       res_err;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit rr_rand = 1'b0;
    logic [8:0] exp_q [$];
    logic [8:0] got;
    logic [8:0] want;

    always #5 clk = ~clk;

    alu_seq #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_a     (start_a),
        .start_b     (start_b),
        .start_first (start_first),
        .start_last  (start_last),
        .abort       (abort),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_opcode  (res_opcode),
        .res_err     (res_err),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural 4-bit ALU; divide/modulo by zero yields F, which the sequencer must mask.
    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'h0, a} * {4'h0, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[3:0];
            OP_DIV:  return (b == 4'h0) ? 4'hF : a / b;
            OP_MOD:  return (b == 4'h0) ? 4'hF : a % b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            OP_ROL:  return {a[2:0], a[3]};
            OP_ROR:  return {a[0], a[3:1]};
            OP_NEG:  return 4'h0 - a;
            OP_INC:  return a + 4'h1;
            OP_DEC:  return a - 4'h1;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    // Reference model: expected {err, opcode, data} stream for one complete job.
    task automatic model_job(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] f, input logic [3:0] l);
        int n;
        logic [3:0] op;
        logic e;
        n = ((int'(l) - int'(f) + 16) % 16) + 1;
        for (int i = 0; i < n; i++) begin
            op = 4'((int'(f) + i) % 16);
            e  = ((op == 4'h3) || (op == 4'h4)) && (b == 4'h0);
            exp_q.push_back({e, op, e ? 4'h0 : alu_fn(op, a, b)});
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_seen++;
        if (rst_n && res_valid && res_ready) begin
            got = {res_err, res_opcode, res_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result actual=%h expected=none (no entry pending)", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result actual=%h expected=%h", got, want);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    // Called and returns at posedge+1.
    task automatic start_job(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] f, input logic [3:0] l);
        int t;
        t = 0;
        while (!start_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!start_ready) begin
            checks++; errors++;
            $display("FAIL start_ready_wait actual=0 expected=1");
        end
        start_valid = 1'b1;
        start_a = a; start_b = b; start_first = f; start_last = l;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        check("idle_and_drained", {31'd0, busy}, 32'd0);
        check("entries_left", exp_q.size(), 32'd0);
    endtask

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  first;
        logic [3:0]  last;
        logic [2:0]  n;
        logic [35:0] exp;
    } vec_t;

    vec_t tbl [5];

    // Table job with res_ready held high: done must show in cycle 2N after accept.
    task automatic run_vec(input int i);
        int k;
        for (int j = 0; j < int'(tbl[i].n); j++) exp_q.push_back(tbl[i].exp[9*j +: 9]);
        done_seen = 0;
        start_job(tbl[i].a, tbl[i].b, tbl[i].first, tbl[i].last);
        k = 1;
        @(negedge clk);
        while (!done && k < 40) begin
            @(negedge clk); k++;
        end
        check($sformatf("vec%0d_done_cycle", i), k, 2 * int'(tbl[i].n));
        check($sformatf("vec%0d_ready_at_done", i), {31'd0, start_ready}, 32'd0);
        @(negedge clk);
        check($sformatf("vec%0d_ready_after_done", i), {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        wait_idle();
        check($sformatf("vec%0d_done_count", i), done_seen, 32'd1);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rf;
        logic [3:0] rl;

        tbl[0] = '{a:4'h5, b:4'h3, first:4'h0, last:4'h0, n:3'd1,
                   exp:{27'd0, 9'b0_0000_1000}};
        tbl[1] = '{a:4'h6, b:4'h0, first:4'h2, last:4'h5, n:3'd4,
                   exp:{9'b0_0101_0000, 9'b1_0100_0000, 9'b1_0011_0000, 9'b0_0010_0000}};
        tbl[2] = '{a:4'h1, b:4'h1, first:4'hE, last:4'h1, n:3'd4,
                   exp:{9'b0_0001_0000, 9'b0_0000_0010, 9'b0_1111_0000, 9'b0_1110_0010}};
        tbl[3] = '{a:4'hA, b:4'h3, first:4'h3, last:4'h4, n:3'd2,
                   exp:{18'd0, 9'b0_0100_0001, 9'b0_0011_0011}};
        tbl[4] = '{a:4'hC, b:4'h5, first:4'h5, last:4'h7, n:3'd3,
                   exp:{9'd0, 9'b0_0111_1001, 9'b0_0110_1101, 9'b0_0101_0100}};

        #1;
        check("reset_outputs",
              {8'd0, alu_a, alu_b, alu_opcode, res_valid, res_data, res_opcode, res_err, busy, done, start_ready},
              32'h0000_0001);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(i);

        // Full sweep with consumer stalled: sequencer parks in CAPTURE on opcode DEPTH.
        res_ready = 1'b0;
        done_seen = 0;
        model_job(4'h7, 4'h2, 4'h0, 4'hF);
        start_job(4'h7, 4'h2, 4'h0, 4'hF);
        repeat (30) @(posedge clk);
        #1;
        check("stall_opcode", {28'd0, alu_opcode}, DEPTH);
        check("stall_busy_valid", {30'd0, busy, res_valid}, 32'd3);
        check("stall_no_done", done_seen, 32'd0);
        res_ready = 1'b1;
        wait_idle();
        check("sweep16_done_count", done_seen, 32'd1);

        // Abort during ISSUE of the second op: one entry kept, no done.
        res_ready = 1'b0;
        done_seen = 0;
        model_job(4'h3, 4'h2, 4'h8, 4'h8);
        start_job(4'h3, 4'h2, 4'h8, 4'hB);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_ready_busy", {30'd0, start_ready, busy}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("abort_fifo_kept", {23'd0, res_valid, res_opcode, res_data}, {23'd0, 1'b1, 4'h8, 4'hC});
        check("abort_no_done", done_seen, 32'd0);
        res_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of a sweep.
        model_job(4'h9, 4'h4, 4'h0, 4'hF);
        start_job(4'h9, 4'h4, 4'h0, 4'hF);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs",
              {8'd0, alu_a, alu_b, alu_opcode, res_valid, res_data, res_opcode, res_err, busy, done, start_ready},
              32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(2);

        // Random jobs with a randomly stalling consumer.
        rr_rand = 1'b1;
        for (int j = 0; j < 20; j++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            rf = 4'($urandom);
            rl = 4'($urandom);
            done_seen = 0;
            model_job(ra, rb, rf, rl);
            start_job(ra, rb, rf, rl);
            wait_idle();
            check($sformatf("rand%0d_done_count", j), done_seen, 32'd1);
        end
        rr_rand = 1'b0;
        @(posedge clk); #2;
        res_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
